// File: rtl/si_tag_lane_scheduler.sv
// Serializes one multi-lane converter beat into a single-tag-per-cycle stream in ascending lane order,
// filtering lanes by a per-channel enable mask and tracking a monotonic lowest-time bound.
module si_tag_lane_scheduler #(
   parameter int unsigned CHANNEL_COUNT   = 20,
   parameter int unsigned NUMBER_OF_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [63:0]                  s_axis_tagtime [NUMBER_OF_WORDS],
   input  logic signed [5:0]            s_axis_channel [NUMBER_OF_WORDS],
   input  logic [NUMBER_OF_WORDS-1:0]   s_axis_tkeep,
   input  logic [63:0]                  s_lowest_time_bound,
   input  logic [2*CHANNEL_COUNT-1:0]   channel_enable,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [63:0]                  m_axis_tagtime,
   output logic signed [5:0]            m_axis_channel,
   output logic                         m_axis_tlast,
   output logic [63:0]                  lowest_time_bound,
   output logic [31:0]                  dropped_tags
);

   localparam int unsigned N  = NUMBER_OF_WORDS;
   localparam int unsigned CC = CHANNEL_COUNT;
   localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(N + 1);

   logic [N-1:0]      pend_keep;
   logic [63:0]       time_q [N];
   logic signed [5:0] chan_q [N];
   logic [63:0]       low_q;
   logic [31:0]       drop_q;

   logic [N-1:0]      lane_en;
   logic [SW-1:0]     sel;
   logic [N-1:0]      sel_oh;
   logic [CW-1:0]     pend_cnt;
   logic [CW-1:0]     drop_inc;
   logic [32:0]       drop_sum;
   logic              issue;
   logic              accept;

   // Channel 0 and out-of-range channels match no enable bit and are therefore masked off.
   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         lane_en[i] = 1'b0;
         for (int j = 0; j < int'(CC); j++) begin
            if ((int'(s_axis_channel[i]) == j + 1) && channel_enable[j]) begin
               lane_en[i] = 1'b1;
            end
            if ((int'(s_axis_channel[i]) == -(j + 1)) && channel_enable[int'(CC) + j]) begin
               lane_en[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel      = '0;
      sel_oh   = '0;
      pend_cnt = '0;
      drop_inc = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (pend_keep[i]) begin
            sel       = SW'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         pend_cnt = pend_cnt + CW'(pend_keep[i]);
         drop_inc = drop_inc + CW'(s_axis_tkeep[i] & ~lane_en[i]);
      end
      drop_sum = {1'b0, drop_q} + 33'(drop_inc);
   end

   always_comb begin
      m_axis_tvalid     = |pend_keep;
      m_axis_tagtime    = m_axis_tvalid ? time_q[sel] : 64'd0;
      m_axis_channel    = m_axis_tvalid ? chan_q[sel] : 6'sd0;
      m_axis_tlast      = (pend_cnt == CW'(1));
      s_axis_tready     = ~m_axis_tvalid | (m_axis_tready & m_axis_tlast);
      issue             = m_axis_tvalid & m_axis_tready;
      accept            = s_axis_tvalid & s_axis_tready;
      lowest_time_bound = low_q;
      dropped_tags      = drop_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_keep <= '0;
         low_q     <= '0;
         drop_q    <= '0;
      end else begin
         // A new beat replaces the one whose last tag is leaving this cycle.
         if (accept) begin
            pend_keep <= s_axis_tkeep & lane_en;
         end else if (issue) begin
            pend_keep <= pend_keep & ~sel_oh;
         end
         if (issue) begin
            low_q <= m_axis_tagtime;
         end else if (!m_axis_tvalid && !accept && (s_lowest_time_bound > low_q)) begin
            low_q <= s_lowest_time_bound;
         end
         if (accept) begin
            drop_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < int'(N); i++) begin
            time_q[i] <= s_axis_tagtime[i];
            chan_q[i] <= s_axis_channel[i];
         end
      end
   end

endmodule

// File: tb/tb_si_tag_lane_scheduler.sv
// Bench for si_tag_lane_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_si_tag_lane_scheduler;

   localparam int N  = 4;
   localparam int CC = 20;
   localparam int EW = 2 * CC;

   logic              clk = 1'b0;
   logic              rst;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [63:0]       s_tt [N];
   logic signed [5:0] s_ch [N];
   logic [N-1:0]      s_axis_tkeep;
   logic [63:0]       s_lowest_time_bound;
   logic [EW-1:0]     channel_enable;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [63:0]       m_axis_tagtime;
   logic signed [5:0] m_axis_channel;
   logic              m_axis_tlast;
   logic [63:0]       lowest_time_bound;
   logic [31:0]       dropped_tags;

   always #5 clk = ~clk;

   si_tag_lane_scheduler #(
      .CHANNEL_COUNT   (CC),
      .NUMBER_OF_WORDS (N)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .s_axis_tvalid       (s_axis_tvalid),
      .s_axis_tready       (s_axis_tready),
      .s_axis_tagtime      (s_tt),
      .s_axis_channel      (s_ch),
      .s_axis_tkeep        (s_axis_tkeep),
      .s_lowest_time_bound (s_lowest_time_bound),
      .channel_enable      (channel_enable),
      .m_axis_tvalid       (m_axis_tvalid),
      .m_axis_tready       (m_axis_tready),
      .m_axis_tagtime      (m_axis_tagtime),
      .m_axis_channel      (m_axis_channel),
      .m_axis_tlast        (m_axis_tlast),
      .lowest_time_bound   (lowest_time_bound),
      .dropped_tags        (dropped_tags)
   );

   typedef struct {
      logic [63:0]       t;
      logic signed [5:0] c;
   } tag_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   chk_en   = 1'b0;
   bit   last_acc = 1'b0;

   // Model: pending tags of the current beat in issue order, plus bound and drop counter.
   tag_t        q[$];
   logic [63:0] m_low  = '0;
   logic [31:0] m_drop = '0;

   tag_t log_q[$];
   bit   log_l[$];
   int   log_cyc[$];

   function automatic bit ch_enabled(logic signed [5:0] c, logic [EW-1:0] en);
      int v;
      v = int'(c);
      if (v > 0 && v <= CC) return en[v-1];
      if (v < 0 && -v <= CC) return en[CC-1-v];
      return 1'b0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      bit                issue, acc, exp_v, exp_l, exp_sr;
      logic [63:0]       exp_t;
      logic signed [5:0] exp_c;
      tag_t              tg;
      #1;
      exp_v  = q.size() > 0;
      exp_t  = exp_v ? q[0].t : 64'd0;
      exp_c  = exp_v ? q[0].c : 6'sd0;
      exp_l  = q.size() == 1;
      exp_sr = !exp_v || (m_axis_tready && exp_l);
      if (chk_en) begin
         chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_v));
         chk("m_tagtime", m_axis_tagtime, exp_t);
         chk("m_channel", m_axis_channel, exp_c);
         chk("m_tlast", 64'(m_axis_tlast), 64'(exp_l));
         chk("s_tready", 64'(s_axis_tready), 64'(exp_sr));
         chk("lowest_bound", lowest_time_bound, m_low);
         chk("dropped", 64'(dropped_tags), 64'(m_drop));
         if (m_axis_tvalid && m_axis_tready) begin
            tg.t = m_axis_tagtime;
            tg.c = m_axis_channel;
            log_q.push_back(tg);
            log_l.push_back(m_axis_tlast);
            log_cyc.push_back(cyc);
         end
      end
      last_acc = s_axis_tvalid && s_axis_tready;
      issue    = exp_v && m_axis_tready;
      acc      = s_axis_tvalid && exp_sr;
      if (rst) begin
         q.delete();
         m_low  = '0;
         m_drop = '0;
      end else begin
         if (issue) m_low = q[0].t;
         else if (!exp_v && !acc && s_lowest_time_bound > m_low) m_low = s_lowest_time_bound;
         if (issue) void'(q.pop_front());
         if (acc) begin
            q.delete();
            for (int i = 0; i < N; i++) begin
               if (s_axis_tkeep[i]) begin
                  if (ch_enabled(s_ch[i], channel_enable)) begin
                     tg.t = s_tt[i];
                     tg.c = s_ch[i];
                     q.push_back(tg);
                  end else if (m_drop != 32'hFFFF_FFFF) begin
                     m_drop++;
                  end
               end
            end
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic send_beat();
      s_axis_tvalid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         step();
         if (last_acc) break;
      end
      if (!last_acc) chk("accept_timeout", 64'(last_acc), 64'd1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic clear_log();
      log_q.delete();
      log_l.delete();
      log_cyc.delete();
   endtask

   task automatic exp_tag(string nm, int k, logic [63:0] t, logic signed [5:0] c, bit l);
      if (k >= log_q.size()) begin
         chk({nm, "_missing"}, 64'(log_q.size()), 64'(k + 1));
      end else begin
         chk({nm, "_time"}, log_q[k].t, t);
         chk({nm, "_chan"}, log_q[k].c, c);
         chk({nm, "_last"}, 64'(log_l[k]), 64'(l));
      end
   endtask

   task automatic set_lane(int i, logic [63:0] t, int c);
      s_tt[i] = t;
      s_ch[i] = 6'(c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tkeep = '0;
      s_lowest_time_bound = '0;
      channel_enable = '1;
      m_axis_tready = 1'b1;
      for (int i = 0; i < N; i++) set_lane(i, 64'd0, 0);
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("reset_sready", 64'(s_axis_tready), 64'd1);
      chk("reset_bound", lowest_time_bound, 64'd0);

      // Sparse keep, lanes issued in ascending order.
      clear_log();
      s_axis_tkeep = 4'b1011;
      set_lane(0, 64'd100, 1);
      set_lane(1, 64'd200, -2);
      set_lane(2, 64'd300, 7);
      set_lane(3, 64'd400, 3);
      send_beat();
      for (int k = 0; k < 4; k++) step();
      chk("t1_count", 64'(log_q.size()), 64'd3);
      exp_tag("t1_0", 0, 64'd100, 1, 1'b0);
      exp_tag("t1_1", 1, 64'd200, -2, 1'b0);
      exp_tag("t1_2", 2, 64'd400, 3, 1'b1);
      if (log_cyc.size() == 3) chk("t1_span", 64'(log_cyc[2] - log_cyc[0]), 64'd2);

      // Back-to-back full beats: no bubble between them.
      clear_log();
      s_axis_tkeep = 4'hF;
      for (int i = 0; i < N; i++) set_lane(i, 64'(1000 + i), i + 1);
      send_beat();
      for (int i = 0; i < N; i++) set_lane(i, 64'(1004 + i), i + 5);
      send_beat();
      for (int k = 0; k < 5; k++) step();
      chk("t2_count", 64'(log_q.size()), 64'd8);
      for (int k = 0; k < 8; k++) exp_tag("t2", k, 64'(1000 + k), 6'(k + 1), (k == 3) || (k == 7));
      if (log_cyc.size() == 8) chk("t2_span", 64'(log_cyc[7] - log_cyc[0]), 64'd7);

      // Consumer stall mid-beat.
      clear_log();
      for (int i = 0; i < N; i++) set_lane(i, 64'(2000 + i), -(i + 1));
      send_beat();
      step();
      m_axis_tready = 1'b0;
      for (int k = 0; k < 3; k++) step();
      m_axis_tready = 1'b1;
      for (int k = 0; k < 5; k++) step();
      chk("t3_count", 64'(log_q.size()), 64'd4);
      for (int k = 0; k < 4; k++) exp_tag("t3", k, 64'(2000 + k), 6'(-(k + 1)), k == 3);

      // Channel -2 masked; then an entirely masked beat.
      do_reset();
      clear_log();
      channel_enable = '1;
      channel_enable[21] = 1'b0;
      set_lane(0, 64'd3000, 1);
      set_lane(1, 64'd3001, -2);
      set_lane(2, 64'd3002, 5);
      set_lane(3, 64'd3003, -2);
      send_beat();
      for (int k = 0; k < 3; k++) step();
      chk("t4_dropped", 64'(dropped_tags), 64'd2);
      chk("t4_count", 64'(log_q.size()), 64'd2);
      exp_tag("t4_0", 0, 64'd3000, 1, 1'b0);
      exp_tag("t4_1", 1, 64'd3002, 5, 1'b1);
      channel_enable = '0;
      c0 = cyc;
      send_beat();
      chk("t4_accept_cycles", 64'(cyc - c0), 64'd1);
      step();
      step();
      chk("t4_masked_count", 64'(log_q.size()), 64'd2);
      chk("t4_dropped2", 64'(dropped_tags), 64'd6);

      // Lowest-time bound tracking.
      do_reset();
      channel_enable = '1;
      s_lowest_time_bound = 64'd5000;
      step();
      chk("t5_bound_5000", lowest_time_bound, 64'd5000);
      s_lowest_time_bound = 64'd4000;
      step();
      chk("t5_bound_hold", lowest_time_bound, 64'd5000);
      s_axis_tkeep = 4'b0001;
      set_lane(0, 64'd6000, 1);
      send_beat();
      step();
      step();
      chk("t5_bound_6000", lowest_time_bound, 64'd6000);

      // Reset while two tags are still pending.
      do_reset();
      s_lowest_time_bound = 64'd0;
      channel_enable = '1;
      channel_enable[21] = 1'b0;
      s_axis_tkeep = 4'hF;
      set_lane(0, 64'd7000, 1);
      set_lane(1, 64'd7001, 2);
      set_lane(2, 64'd7002, 3);
      set_lane(3, 64'd7003, -2);
      send_beat();
      step();
      chk("t6_pre_dropped", 64'(dropped_tags), 64'd1);
      chk("t6_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
      do_reset();
      chk("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t6_dropped", 64'(dropped_tags), 64'd0);
      chk("t6_bound", lowest_time_bound, 64'd0);
      chk("t6_sready", 64'(s_axis_tready), 64'd1);
      clear_log();
      s_axis_tkeep = 4'b0011;
      set_lane(0, 64'd8000, 4);
      set_lane(1, 64'd8001, -4);
      send_beat();
      for (int k = 0; k < 3; k++) step();
      chk("t6_count", 64'(log_q.size()), 64'd2);
      exp_tag("t6_0", 0, 64'd8000, 4, 1'b0);
      exp_tag("t6_1", 1, 64'd8001, -4, 1'b1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         s_axis_tvalid = $urandom_range(0, 2) != 0;
         s_axis_tkeep  = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            s_tt[i] = {$urandom, $urandom};
            s_ch[i] = 6'(int'($urandom_range(0, 44)) - 22);
         end
         m_axis_tready = $urandom_range(0, 3) != 0;
         channel_enable = ($urandom_range(0, 3) == 0) ? EW'({$urandom, $urandom}) : '1;
         s_lowest_time_bound = {$urandom, $urandom};
         rst = $urandom_range(0, 199) == 0;
         step();
      end
      rst = 1'b0;
      s_axis_tvalid = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
